// File: rtl/change_dispenser_if.sv
// Request / coin-ejector / refill / inventory bundle for the change dispenser.
// The requester side (vending FSM, ejector, refill logic) is the master.
interface change_dispenser_if #(
    parameter int AMT_W = 8,
    parameter int CNT_W = 6
);
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic             coin_valid;
    logic [1:0]       coin_type;
    logic             coin_ack;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] remaining;
    logic             refill_valid;
    logic [1:0]       refill_type;
    logic [CNT_W-1:0] refill_count;
    logic [CNT_W-1:0] q_cnt;
    logic [CNT_W-1:0] d_cnt;
    logic [CNT_W-1:0] n_cnt;

    modport master (
        output req_valid, req_amount, coin_ack, refill_valid, refill_type, refill_count,
        input  req_ready, coin_valid, coin_type, done, short, remaining, q_cnt, d_cnt, n_cnt
    );

    modport slave (
        input  req_valid, req_amount, coin_ack, refill_valid, refill_type, refill_count,
        output req_ready, coin_valid, coin_type, done, short, remaining, q_cnt, d_cnt, n_cnt
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy quarter/dime/nickel change payout, one coin per ejector handshake,
// with per-type saturating inventory and shortfall reporting.
module change_dispenser #(
    parameter int AMT_W  = 8,
    parameter int CNT_W  = 6,
    parameter int Q_INIT = 10,
    parameter int D_INIT = 10,
    parameter int N_INIT = 10
) (
    input  logic               clk,
    input  logic               rst,
    change_dispenser_if.slave  bus
);
    // state  | meaning
    // IDLE   | waiting for a change request
    // SELECT | choose largest affordable coin in stock
    // ISSUE  | coin presented to ejector until coin_ack
    // DONE   | one-cycle completion pulse
    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_ISSUE, S_DONE} state_t;

    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_NICK = 2'b01;
    localparam logic [1:0] T_DIME = 2'b10;
    localparam logic [1:0] T_QUAR = 2'b11;
    localparam logic [AMT_W-1:0] V_NICK = AMT_W'(5);
    localparam logic [AMT_W-1:0] V_DIME = AMT_W'(10);
    localparam logic [AMT_W-1:0] V_QUAR = AMT_W'(25);
    localparam logic [CNT_W:0]   CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    state_t           state, state_nxt;
    logic [AMT_W-1:0] remaining;
    logic [1:0]       sel_type;
    logic [1:0]       pick;
    logic [CNT_W-1:0] q_cnt, d_cnt, n_cnt;
    logic             ack_take;

    function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] t);
        case (t)
            T_QUAR:  return V_QUAR;
            T_DIME:  return V_DIME;
            T_NICK:  return V_NICK;
            default: return '0;
        endcase
    endfunction

    // A decrement only happens on a nonzero count, so the sum cannot go negative.
    function automatic logic [CNT_W-1:0] sat_update(input logic [CNT_W-1:0] c,
                                                     input logic [CNT_W-1:0] a,
                                                     input logic             d);
        logic [CNT_W:0] s;
        s = {1'b0, c} + {1'b0, a} - {{CNT_W{1'b0}}, d};
        return (s > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : s[CNT_W-1:0];
    endfunction

    always_comb begin
        pick = T_NONE;
        if (remaining >= V_QUAR && q_cnt != '0)
            pick = T_QUAR;
        else if (remaining >= V_DIME && d_cnt != '0)
            pick = T_DIME;
        else if (remaining >= V_NICK && n_cnt != '0)
            pick = T_NICK;
    end

    assign ack_take = (state == S_ISSUE) && bus.coin_ack;

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.req_valid) state_nxt = S_SELECT;
            S_SELECT: state_nxt = (pick != T_NONE) ? S_ISSUE : S_DONE;
            S_ISSUE:  if (bus.coin_ack) state_nxt = S_SELECT;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state == S_IDLE);
        bus.coin_valid = (state == S_ISSUE);
        bus.coin_type  = (state == S_ISSUE) ? sel_type : T_NONE;
        bus.done       = (state == S_DONE);
        bus.short      = (state == S_DONE) && (remaining != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            sel_type  <= T_NONE;
        end else begin
            case (state)
                S_IDLE:   if (bus.req_valid) remaining <= bus.req_amount;
                S_SELECT: sel_type <= pick;
                S_ISSUE:  if (bus.coin_ack) remaining <= remaining - coin_value(sel_type);
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_cnt <= CNT_W'(Q_INIT);
            d_cnt <= CNT_W'(D_INIT);
            n_cnt <= CNT_W'(N_INIT);
        end else begin
            q_cnt <= sat_update(q_cnt,
                                (bus.refill_valid && bus.refill_type == T_QUAR) ? bus.refill_count : '0,
                                ack_take && sel_type == T_QUAR);
            d_cnt <= sat_update(d_cnt,
                                (bus.refill_valid && bus.refill_type == T_DIME) ? bus.refill_count : '0,
                                ack_take && sel_type == T_DIME);
            n_cnt <= sat_update(n_cnt,
                                (bus.refill_valid && bus.refill_type == T_NICK) ? bus.refill_count : '0,
                                ack_take && sel_type == T_NICK);
        end
    end

    assign bus.remaining = remaining;
    assign bus.q_cnt     = q_cnt;
    assign bus.d_cnt     = d_cnt;
    assign bus.n_cnt     = n_cnt;
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: three instances with different initial
// inventories, one selected at a time through a shared stimulus/observe mux.
module tb_change_dispenser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int sel = 0;
    logic       req_valid = 1'b0;
    logic [7:0] req_amount = '0;
    logic       coin_ack = 1'b0;
    logic       refill_valid = 1'b0;
    logic [1:0] refill_type = '0;
    logic [5:0] refill_count = '0;

    change_dispenser_if #(.AMT_W(8), .CNT_W(6)) if_a ();
    change_dispenser_if #(.AMT_W(8), .CNT_W(6)) if_b ();
    change_dispenser_if #(.AMT_W(8), .CNT_W(6)) if_c ();

    change_dispenser #(.AMT_W(8), .CNT_W(6), .Q_INIT(10), .D_INIT(10), .N_INIT(10))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    change_dispenser #(.AMT_W(8), .CNT_W(6), .Q_INIT(0), .D_INIT(10), .N_INIT(10))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    change_dispenser #(.AMT_W(8), .CNT_W(6), .Q_INIT(10), .D_INIT(0), .N_INIT(1))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));

    assign if_a.req_valid    = (sel == 0) && req_valid;
    assign if_a.req_amount   = req_amount;
    assign if_a.coin_ack     = (sel == 0) && coin_ack;
    assign if_a.refill_valid = (sel == 0) && refill_valid;
    assign if_a.refill_type  = refill_type;
    assign if_a.refill_count = refill_count;
    assign if_b.req_valid    = (sel == 1) && req_valid;
    assign if_b.req_amount   = req_amount;
    assign if_b.coin_ack     = (sel == 1) && coin_ack;
    assign if_b.refill_valid = (sel == 1) && refill_valid;
    assign if_b.refill_type  = refill_type;
    assign if_b.refill_count = refill_count;
    assign if_c.req_valid    = (sel == 2) && req_valid;
    assign if_c.req_amount   = req_amount;
    assign if_c.coin_ack     = (sel == 2) && coin_ack;
    assign if_c.refill_valid = (sel == 2) && refill_valid;
    assign if_c.refill_type  = refill_type;
    assign if_c.refill_count = refill_count;

    logic       o_ready, o_cv, o_done, o_short;
    logic [1:0] o_ct;
    logic [7:0] o_rem;
    logic [5:0] o_q, o_d, o_n;

    always_comb begin
        o_ready = if_a.req_ready; o_cv = if_a.coin_valid; o_ct = if_a.coin_type;
        o_done = if_a.done; o_short = if_a.short; o_rem = if_a.remaining;
        o_q = if_a.q_cnt; o_d = if_a.d_cnt; o_n = if_a.n_cnt;
        if (sel == 1) begin
            o_ready = if_b.req_ready; o_cv = if_b.coin_valid; o_ct = if_b.coin_type;
            o_done = if_b.done; o_short = if_b.short; o_rem = if_b.remaining;
            o_q = if_b.q_cnt; o_d = if_b.d_cnt; o_n = if_b.n_cnt;
        end else if (sel == 2) begin
            o_ready = if_c.req_ready; o_cv = if_c.coin_valid; o_ct = if_c.coin_type;
            o_done = if_c.done; o_short = if_c.short; o_rem = if_c.remaining;
            o_q = if_c.q_cnt; o_d = if_c.d_cnt; o_n = if_c.n_cnt;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and service coins; ends one cycle after done (back in IDLE).
    task automatic run_req(input int amount, input int delay,
                           output int ncoin, output logic [3:0][1:0] coins,
                           output int lat, output logic sh, output logic [7:0] rem,
                           output bit timeout);
        ncoin = 0; lat = -1; sh = 1'b0; rem = '0; timeout = 1'b1; coins = '0;
        req_valid = 1'b1;
        req_amount = 8'(amount);
        tick();
        req_valid = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (o_done) begin
                if (lat < 0) lat = i;
                sh = o_short;
                rem = o_rem;
                timeout = 1'b0;
                break;
            end
            if (o_cv) begin
                if (lat < 0) lat = i;
                if (ncoin < 4) coins[ncoin] = o_ct;
                ncoin++;
                for (int k = 1; k < delay; k++) tick();
                coin_ack = 1'b1;
                tick();
                coin_ack = 1'b0;
            end
        end
        tick();
    endtask

    typedef struct {
        int              sel;
        int              amount;
        int              delay;
        int              ncoin;
        logic [3:0][1:0] coins;
        int              shortv;
        int              rem;
        int              q, d, n;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int              nc, lat;
        logic [3:0][1:0] cs;
        logic            sh;
        logic [7:0]      rm;
        bit              to;

        // coins listed lowest index first: {c3, c2, c1, c0}
        vecs[0] = '{0, 40, 1, 3, {2'b00, 2'b01, 2'b10, 2'b11}, 0, 0, 9, 9, 9};
        vecs[1] = '{1, 30, 1, 3, {2'b00, 2'b10, 2'b10, 2'b10}, 0, 0, 0, 7, 10};
        vecs[2] = '{0, 3,  1, 0, {2'b00, 2'b00, 2'b00, 2'b00}, 1, 3, 9, 9, 9};
        vecs[3] = '{2, 10, 1, 1, {2'b00, 2'b00, 2'b00, 2'b01}, 1, 5, 10, 0, 0};
        vecs[4] = '{0, 0,  1, 0, {2'b00, 2'b00, 2'b00, 2'b00}, 0, 0, 9, 9, 9};
        vecs[5] = '{0, 65, 3, 4, {2'b01, 2'b10, 2'b11, 2'b11}, 0, 0, 7, 8, 8};
        vecs[6] = '{1, 15, 2, 2, {2'b00, 2'b00, 2'b01, 2'b10}, 0, 0, 0, 6, 9};

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_ready", int'(o_ready), 1);
        check("rst_coin_valid", int'(o_cv), 0);
        check("rst_coin_type", int'(o_ct), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_short", int'(o_short), 0);
        check("rst_remaining", int'(o_rem), 0);
        check("rst_q", int'(o_q), 10);
        check("rst_d", int'(o_d), 10);
        check("rst_n", int'(o_n), 10);

        for (int v = 0; v < 7; v++) begin
            sel = vecs[v].sel;
            #1;
            run_req(vecs[v].amount, vecs[v].delay, nc, cs, lat, sh, rm, to);
            check($sformatf("v%0d_timeout", v), int'(to), 0);
            check($sformatf("v%0d_latency", v), lat, 1);
            check($sformatf("v%0d_ncoins", v), nc, vecs[v].ncoin);
            for (int c = 0; c < vecs[v].ncoin && c < 4; c++)
                check($sformatf("v%0d_coin%0d", v, c), int'(cs[c]), int'(vecs[v].coins[c]));
            check($sformatf("v%0d_short", v), int'(sh), vecs[v].shortv);
            check($sformatf("v%0d_remaining", v), int'(rm), vecs[v].rem);
            check($sformatf("v%0d_rem_hold", v), int'(o_rem), vecs[v].rem);
            check($sformatf("v%0d_ready_after", v), int'(o_ready), 1);
            check($sformatf("v%0d_done_one_cycle", v), int'(o_done), 0);
            check($sformatf("v%0d_q", v), int'(o_q), vecs[v].q);
            check($sformatf("v%0d_d", v), int'(o_d), vecs[v].d);
            check($sformatf("v%0d_n", v), int'(o_n), vecs[v].n);
        end

        // Ejector stall with same-edge quarter refill.
        sel = 0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        req_valid = 1'b1; req_amount = 8'd25;
        tick();
        req_valid = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d_valid", k), int'(o_cv), 1);
            check($sformatf("stall%0d_type", k), int'(o_ct), 3);
            tick();
        end
        coin_ack = 1'b1;
        refill_valid = 1'b1; refill_type = 2'b11; refill_count = 6'd3;
        tick();
        coin_ack = 1'b0; refill_valid = 1'b0;
        check("stall_q_after_ack_refill", int'(o_q), 12);
        check("stall_valid_dropped", int'(o_cv), 0);
        tick();
        check("stall_done", int'(o_done), 1);
        check("stall_short", int'(o_short), 0);
        check("stall_remaining", int'(o_rem), 0);
        tick();

        // Saturation and ignored type-00 refill.
        refill_valid = 1'b1; refill_type = 2'b11; refill_count = 6'd60;
        tick();
        check("sat_q", int'(o_q), 63);
        refill_type = 2'b00; refill_count = 6'd5;
        tick();
        refill_valid = 1'b0;
        check("null_refill_q", int'(o_q), 63);
        check("null_refill_d", int'(o_d), 10);
        check("null_refill_n", int'(o_n), 10);

        // Reset while the second coin is on offer.
        req_valid = 1'b1; req_amount = 8'd40;
        tick();
        req_valid = 1'b0;
        tick();
        check("mid_coin1_type", int'(o_ct), 3);
        coin_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        tick();
        check("mid_coin2_valid", int'(o_cv), 1);
        check("mid_coin2_type", int'(o_ct), 2);
        rst = 1'b1;
        tick();
        check("mid_rst_ready", int'(o_ready), 1);
        check("mid_rst_valid", int'(o_cv), 0);
        check("mid_rst_done", int'(o_done), 0);
        check("mid_rst_remaining", int'(o_rem), 0);
        check("mid_rst_q", int'(o_q), 10);
        check("mid_rst_d", int'(o_d), 10);
        check("mid_rst_n", int'(o_n), 10);
        rst = 1'b0;
        tick();
        check("mid_post_done", int'(o_done), 0);
        check("mid_post_ready", int'(o_ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Payout end of the vending machine's money path. The coin acceptor and FSM credit money in; this block pays change out. It takes one change request in cents, issues coins one at a time to the coin-ejector mechanism using a greedy quarter/dime/nickel selection against its own per-type inventory, and reports completion. If the inventory cannot cover the amount, it reports a shortfall and the unpaid residue.

## Interface
Parameters:
- AMT_W, 8, width of amounts in cents
- CNT_W, 6, width of each inventory counter
- Q_INIT, 10, quarter inventory after reset
- D_INIT, 10, dime inventory after reset
- N_INIT, 10, nickel inventory after reset

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  change request present
- req_amount  in  AMT_W  change owed, in cents
- req_ready  out  1  block idle; high only in IDLE
- coin_valid  out  1  coin issue request to ejector
- coin_type  out  2  01 nickel (5), 10 dime (10), 11 quarter (25); 00 when coin_valid=0
- coin_ack  in  1  ejector has released the coin
- done  out  1  one-cycle pulse at end of every request
- short  out  1  one-cycle pulse, coincident with done, when the residue is nonzero
- remaining  out  AMT_W  unpaid amount; holds after done until the next accept
- refill_valid  in  1  add coins to inventory
- refill_type  in  2  coin type to refill; encoding as coin_type; 00 is ignored
- refill_count  in  CNT_W  number of coins added
- q_cnt, d_cnt, n_cnt  out  CNT_W each  current inventory per type

## Operation
- States: IDLE, SELECT, ISSUE, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch remaining<=req_amount and go to SELECT.
- SELECT (exactly one cycle): pick the largest coin whose value is <= remaining and whose count is > 0, using registered counts.
  - Pick found: latch coin_type and go to ISSUE.
  - remaining==0: go to DONE with short=0.
  - remaining>0 and no pick: go to DONE with short=1. This covers amounts not reachable with nickels, e.g. 3.
- ISSUE:
  - coin_valid=1 and coin_type stable until coin_ack.
  - On coin_ack: remaining -= value, selected count -= 1, go to SELECT.
- DONE: done=1 (and short if applicable) for one cycle, then IDLE.
- coin_ack outside ISSUE is ignored.
- req_valid outside IDLE is ignored; the requester must hold it until req_ready.
- Refill:
  - Accepted in any state; applied at the next edge.
  - count <= min(count + refill_count, 2^CNT_W-1).
  - If a same-type coin_ack decrement lands on the same edge: count <= min(count + refill_count - 1, 2^CNT_W-1).
  - A refill seen on the edge that enters SELECT is visible to that SELECT.
- Arithmetic:
  - remaining never underflows, because selection guarantees value <= remaining.
  - Coin values are compared at AMT_W width.
- Reset values:
  - state IDLE, req_ready=1.
  - coin_valid=0, coin_type=00, done=0, short=0, remaining=0.
  - q/d/n_cnt = Q_INIT/D_INIT/N_INIT.
- Reset mid-operation aborts the request with no done pulse. A coin that is in flight is simply dropped.

## Timing
- Handshake at edge T0 (IDLE, req_valid=1). SELECT runs in the cycle after T0. coin_valid is first high in the second cycle after T0.
- coin_ack sampled at edge Tk. coin_valid drops after Tk, SELECT runs for one cycle, and the next coin_valid rises one cycle later. Each coin costs a minimum of 2 cycles plus ejector wait.
- Amount 0: done pulses in the second cycle after the handshake, with short=0.
- req_ready returns to 1 in the cycle after the done pulse.
- Outputs are registered. No combinational path from coin_ack or req_valid to any output.

## Test plan
- Reset check: assert rst for 2 cycles and release. Require req_ready=1, coin_valid=0, done=0, remaining=0, q/d/n_cnt=10/10/10.
- Normal payout: request 40 with coin_ack returned 1 cycle after each coin_valid.
  - Require the coin sequence 11, 10, 01.
  - Require done=1 with short=0 and remaining=0.
  - Require counts 9/9/9.
- Depleted type: q_cnt=0 via reset parameter Q_INIT=0, request 30. Require 10, 10, 10, done, short=0, d_cnt=7.
- Shortfall: request 3. Require no coin_valid, done=1 with short=1, remaining=3. Then request 10 with D_INIT=0 and N_INIT=1: require one 01 coin, short=1, remaining=5.
- Ejector stall plus refill: request 25 and hold coin_ack low for 5 cycles.
  - Require coin_valid and coin_type=11 stable throughout.
  - On the ack edge also apply a refill of type 11, count 3: require q_cnt=12.
  - Separately, refill a count near 63: require saturation at 63.
- Reset mid-dispense: request 40, assert rst while the second coin is valid. Require an immediate return to reset values, no done pulse, and inventory reloaded to the INIT values.
